// File: rtl/array_arbiter.sv
// array_arbiter: shares one lookup array between N_REQ requesters.
// Round-robin grant among requesters, background address sweep when idle,
// and a valid-qualified tag pipeline that follows the array read latency so
// every issue yields exactly one in-order response.
module array_arbiter #(
  parameter  int N_REQ      = 2,
  parameter  int ADDR_WIDTH = 2,
  parameter  int DATA_WIDTH = 18,
  parameter  int ARRAY_LAT  = 0,
  localparam int ID_WIDTH   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         sweep_en,
  output logic [ADDR_WIDTH-1:0]        arr_addr,
  input  logic signed [DATA_WIDTH-1:0] arr_data,
  output logic                         rsp_valid,
  output logic [ID_WIDTH-1:0]          rsp_id,
  output logic                         rsp_sweep,
  output logic signed [DATA_WIDTH-1:0] rsp_data
);

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic [ID_WIDTH-1:0]   grant_id;
  logic                  grant_any;
  logic                  sweep_issue;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] scnt;

  logic [ARRAY_LAT:0]                pv;
  logic [ARRAY_LAT:0]                psw;
  logic [ARRAY_LAT:0][ID_WIDTH-1:0]  pid;

  // Round-robin pick: first valid at or above ptr, else first valid below it.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_any && req_valid[i] && (ID_WIDTH'(i) >= ptr)) begin
          grant_any = 1'b1;
          grant_id  = ID_WIDTH'(i);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_any && req_valid[i]) begin
          grant_any = 1'b1;
          grant_id  = ID_WIDTH'(i);
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        req_ready[i] = grant_any && (grant_id == ID_WIDTH'(i));
      end
    end
  end

  // Issue selection: granted requester address, otherwise the sweep counter.
  always_comb begin
    issue_addr  = scnt;
    sweep_issue = rst && (req_valid == '0) && sweep_en;
    issue       = grant_any || sweep_issue;
    ptr_nxt     = (grant_id == ID_WIDTH'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_any && (grant_id == ID_WIDTH'(i))) begin
        issue_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Arbitration state and the registered array address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      scnt     <= '0;
      arr_addr <= '0;
    end else begin
      if (grant_any)   ptr      <= ptr_nxt;
      if (sweep_issue) scnt     <= scnt + 1'b1;
      if (issue)       arr_addr <= issue_addr;
    end
  end

  // Tag pipeline: one stage for the address register plus ARRAY_LAT stages.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv  <= '0;
      psw <= '0;
      pid <= '0;
    end else begin
      pv[0]  <= issue;
      psw[0] <= sweep_issue;
      pid[0] <= grant_id;
      for (int s = 1; s <= ARRAY_LAT; s++) begin
        pv[s]  <= pv[s-1];
        psw[s] <= psw[s-1];
        pid[s] <= pid[s-1];
      end
    end
  end

  // Response capture: strobe for one cycle, payload holds between responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sweep <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= pv[ARRAY_LAT];
      if (pv[ARRAY_LAT]) begin
        rsp_id    <= pid[ARRAY_LAT];
        rsp_sweep <= psw[ARRAY_LAT];
        rsp_data  <= arr_data;
      end
    end
  end

endmodule

// File: tb/tb_array_arbiter.sv
// Bench for array_arbiter: two instances (ARRAY_LAT 0 and 1) share stimulus.
// Each step's vector carries the expected grant and issued address; issues
// push expected responses to per-instance queues checked on arrival.
module tb_array_arbiter;
  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N*AW-1:0]      req_addr = '0;
  logic                 sweep_en = 1'b0;
  logic [N-1:0]         rdy0, rdy1;
  logic [AW-1:0]        aaddr0, aaddr1;
  logic signed [DW-1:0] adata0, adata1;
  logic                 rv0, rv1, id0, id1, sw0, sw1;
  logic signed [DW-1:0] rd0, rd1;

  function automatic logic signed [DW-1:0] arr_fn(input logic [AW-1:0] a);
    return DW'(16 * int'(a) + 3);
  endfunction

  // Array models: combinational read for LAT 0, registered read for LAT 1.
  assign adata0 = arr_fn(aaddr0);
  always @(posedge clk) adata1 <= arr_fn(aaddr1);

  array_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARRAY_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy0), .sweep_en(sweep_en), .arr_addr(aaddr0), .arr_data(adata0),
    .rsp_valid(rv0), .rsp_id(id0), .rsp_sweep(sw0), .rsp_data(rd0));

  array_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARRAY_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy1), .sweep_en(sweep_en), .arr_addr(aaddr1), .arr_data(adata1),
    .rsp_valid(rv1), .rsp_id(id1), .rsp_sweep(sw1), .rsp_data(rd1));

  typedef struct {
    logic       r;
    logic [1:0] v;
    logic [1:0] a0;
    logic [1:0] a1;
    logic       sw;
    logic [1:0] er;
    logic       es;
    logic [1:0] ia;
  } vec_t;

  typedef struct {
    int                   due;
    logic                 id;
    logic                 sw;
    logic signed [DW-1:0] d;
  } exp_t;

  exp_t      q0[$];
  exp_t      q1[$];
  exp_t      last [2];
  logic      hold_ok = 1'b0;
  logic [AW-1:0] exp_arr = '0;
  int        checks = 0;
  int        errors = 0;
  int        cyc = 0;
  vec_t      tbl [28];

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] a0,
                              input logic [1:0] a1, input logic sw, input logic [1:0] er,
                              input logic es, input logic [1:0] ia);
    vec_t t;
    t.r = r; t.v = v; t.a0 = a0; t.a1 = a1; t.sw = sw; t.er = er; t.es = es; t.ia = ia;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_rsp(input int k, input logic v, input logic id, input logic sw,
                         input logic signed [DW-1:0] d);
    exp_t e;
    logic due;
    due = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin due = 1'b1; e = q0.pop_front(); end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin due = 1'b1; e = q1.pop_front(); end
    end
    chk($sformatf("rsp_valid%0d", k), 32'(v), 32'(due));
    if (due) last[k] = e;
    if (hold_ok) begin
      chk($sformatf("rsp_id%0d", k), 32'(id), 32'(last[k].id));
      chk($sformatf("rsp_sweep%0d", k), 32'(sw), 32'(last[k].sw));
      chk($sformatf("rsp_data%0d", k), 32'(d), 32'(last[k].d));
    end
  endtask

  task automatic step(input vec_t t);
    exp_t e;
    @(negedge clk);
    rst       = t.r;
    req_valid = t.v;
    req_addr  = {t.a1, t.a0};
    sweep_en  = t.sw;
    #1;
    if (cyc > 0) begin
      chk_rsp(0, rv0, id0, sw0, rd0);
      chk_rsp(1, rv1, id1, sw1, rd1);
      chk("arr_addr0", 32'(aaddr0), 32'(exp_arr));
      chk("arr_addr1", 32'(aaddr1), 32'(exp_arr));
    end
    chk("req_ready0", 32'(rdy0), 32'(t.er));
    chk("req_ready1", 32'(rdy1), 32'(t.er));
    if (!t.r) begin
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
        last[k].id = 1'b0; last[k].sw = 1'b0; last[k].d = '0; last[k].due = 0;
      end
      hold_ok = 1'b1;
      exp_arr = '0;
    end else if (t.er != 2'b00 || t.es) begin
      e.id = t.er[1];
      e.sw = t.es;
      e.d  = arr_fn(t.ia);
      e.due = cyc + 2; q0.push_back(e);
      e.due = cyc + 3; q1.push_back(e);
      exp_arr = t.ia;
    end
    cyc++;
  endtask

  initial begin
    // r, valid, a0, a1, sweep_en, exp ready, exp sweep issue, issued addr
    tbl[0]  = mk(0, 2'b11, 1, 3, 0, 2'b00, 0, 0);   // reset with all requests
    tbl[1]  = mk(0, 2'b11, 1, 3, 0, 2'b00, 0, 0);
    tbl[2]  = mk(0, 2'b11, 1, 3, 0, 2'b00, 0, 0);
    tbl[3]  = mk(1, 2'b11, 1, 3, 0, 2'b01, 0, 1);   // alternating grants
    tbl[4]  = mk(1, 2'b11, 1, 3, 0, 2'b10, 0, 3);
    tbl[5]  = mk(1, 2'b11, 1, 3, 0, 2'b01, 0, 1);
    tbl[6]  = mk(1, 2'b11, 1, 3, 0, 2'b10, 0, 3);
    tbl[7]  = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[8]  = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[9]  = mk(1, 2'b10, 0, 2, 0, 2'b10, 0, 2);   // single request from 1
    tbl[10] = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[11] = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[12] = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[13] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 0);   // sweep with wrap
    tbl[14] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 1);
    tbl[15] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 2);
    tbl[16] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 3);
    tbl[17] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 0);
    tbl[18] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 1);
    tbl[19] = mk(1, 2'b01, 3, 0, 1, 2'b01, 0, 3);   // request preempts sweep at 2
    tbl[20] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 2);
    tbl[21] = mk(1, 2'b00, 0, 0, 1, 2'b00, 1, 3);
    tbl[22] = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);   // sweep disabled, scnt holds
    tbl[23] = mk(1, 2'b11, 0, 1, 0, 2'b10, 0, 1);   // ptr=1 picks requester 1
    tbl[24] = mk(1, 2'b01, 2, 0, 0, 2'b01, 0, 2);
    tbl[25] = mk(1, 2'b10, 0, 3, 1, 2'b10, 0, 3);
    tbl[26] = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);
    tbl[27] = mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0);

    for (int i = 0; i < 28; i++) step(tbl[i]);

    // In-flight lookup killed by a one-cycle reset, then first cycle out of
    // reset grants the lowest valid requester.
    step(mk(1, 2'b10, 0, 1, 0, 2'b10, 0, 1));
    step(mk(0, 2'b11, 2, 3, 0, 2'b00, 0, 0));
    step(mk(1, 2'b11, 2, 3, 0, 2'b01, 0, 2));
    for (int i = 0; i < 4; i++) step(mk(1, 2'b00, 0, 0, 0, 2'b00, 0, 0));

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/array_arbiter.md
ARRAY_ARBITER -- requirements
Module: array_arbiter

Interface
REQ-001 Parameter N_REQ, default 2: number of requesters sharing the array, 2..8.
REQ-002 Parameter ADDR_WIDTH, default 2: array address width.
REQ-003 Parameter DATA_WIDTH, default 18: signed fixed-point width of array data.
REQ-004 Parameter ARRAY_LAT, default 0: cycles from arr_addr change to valid arr_data, 0 or 1.
REQ-005 Port clk  in  1  single clock; all state changes on rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-low.
REQ-007 Port req_valid  in  N_REQ  lookup request per requester.
REQ-008 Port req_addr  in  N_REQ*ADDR_WIDTH  requester i address at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port req_ready  out  N_REQ  one-hot or zero grant; combinational from req_valid and internal state.
REQ-010 Port sweep_en  in  1  enables background address sweep when idle.
REQ-011 Port arr_addr  out  ADDR_WIDTH  registered address driven to the array addr port.
REQ-012 Port arr_data  in  DATA_WIDTH  signed array output.
REQ-013 Port rsp_valid  out  1  registered one-cycle response strobe.
REQ-014 Port rsp_id  out  max(1,clog2(N_REQ))  requester index of response.
REQ-015 Port rsp_sweep  out  1  response originates from sweep, not a requester.
REQ-016 Port rsp_data  out  DATA_WIDTH  registered signed lookup result.

Function
REQ-017 At most one issue per cycle; a requester transfer occurs in cycle T when req_valid[i] and req_ready[i] are both 1.
REQ-018 req_ready[i] asserts only for the requester chosen by round-robin search starting at pointer ptr; zero when no req_valid bit is set.
REQ-019 After a transfer from requester i, ptr becomes (i+1) mod N_REQ; ptr is unchanged in cycles without a requester transfer.
REQ-020 A requester holding req_valid without ready keeps its request; withdrawal before transfer is legal and causes no issue.
REQ-021 When no req_valid bit is set and sweep_en=1, a sweep issue occurs using sweep counter scnt.
REQ-022 After a sweep issue, scnt increments modulo 2^ADDR_WIDTH (wraps max to 0); scnt holds when preempted by a request or when sweep_en=0.
REQ-023 On any issue in cycle T, arr_addr takes the issued address at the end of T and holds it until the next issue.
REQ-024 Each issue is tagged (id, sweep flag) in a valid-qualified pipeline of depth 1+ARRAY_LAT tracking the array latency.
REQ-025 arr_data is sampled at the end of cycle T+1+ARRAY_LAT into rsp_data; rsp_valid, rsp_id and rsp_sweep assert in cycle T+2+ARRAY_LAT for exactly one cycle.
REQ-026 Responses return in issue order; back-to-back issues yield back-to-back responses with no bubble.
REQ-027 In cycles without a response, rsp_valid=0 and rsp_data, rsp_id, rsp_sweep hold their last values.
REQ-028 rsp_id is 0 and rsp_sweep is 1 for sweep responses.
REQ-029 rsp_data is a bit-exact copy of arr_data; no rounding, sign change or width conversion.

Reset
REQ-030 While rst=0 at a clock edge: ptr=0, scnt=0, arr_addr=0, pipeline valids cleared, rsp_valid=0, rsp_id=0, rsp_sweep=0, rsp_data=0.
REQ-031 req_ready is all-zero whenever rst=0, regardless of req_valid.
REQ-032 Lookups in flight when rst is asserted are discarded and never produce rsp_valid after release.
REQ-033 The first cycle with rst=1 may accept a transfer, granting the lowest-index valid requester.

Verification
REQ-034 rst=0 for 3 cycles with req_valid all ones -> req_ready=0, rsp_valid=0, arr_addr=0 throughout.
REQ-035 N_REQ=2, ARRAY_LAT=0, bench array returns 16*addr+3; requester 1 single request addr 2 -> arr_addr=2 next cycle, one rsp_valid pulse 2 cycles after transfer, rsp_id=1, rsp_data=35, rsp_sweep=0.
REQ-036 Both requesters continuously valid, addrs 1 and 3 -> grants 0,1,0,1 from reset; rsp_data 19,51,19,51 every cycle, ids alternating.
REQ-037 sweep_en=1, no requests, ADDR_WIDTH=2 -> arr_addr 0,1,2,3,0,1; continuous responses with rsp_sweep=1, data 3,19,35,51,3.
REQ-038 Sweep at scnt=2, requester 0 valid one cycle addr 3 -> request issued (rsp_data=51, rsp_id=0), sweep resumes at addr 2.
REQ-039 ARRAY_LAT=1, transfer in cycle T, rst=0 in T+1 for 1 cycle -> no rsp_valid in T+3 or later for that lookup.
